// File: rtl/riscv_constants.sv
// ---------------------------------------------------------------------------
// riscv_constants
// Shared constants for the operand-select stage and its forwarding units.
//   OP1_SEL    : operand 1 source (register rs1, program counter, zero-ext imm)
//   OP2_SEL    : operand 2 source (register rs2, immediate)
//   regMatch() : "this writer targets this source register" test, x0 excluded
// ---------------------------------------------------------------------------
package riscv_constants;

  typedef enum logic [1:0] {
    OP1_RS1 = 2'd0,
    OP1_PC  = 2'd1,
    OP1_IMZ = 2'd2
  } OP1_SEL;

  typedef enum logic [1:0] {
    OP2_RS2 = 2'd0,
    OP2_IMM = 2'd1
  } OP2_SEL;

  // x0 is hard-wired to zero, so a writer aimed at it never produces a
  // forwarding hit or a hazard.
  function automatic logic regMatch(input logic       valid,
                                    input logic [4:0] rd,
                                    input logic [4:0] addr);
    return valid && (rd == addr) && (addr != 5'd0);
  endfunction

endpackage

// File: rtl/riscv_fwd_unit.sv
// ---------------------------------------------------------------------------
// riscv_fwd_unit
// Resolves one register source operand against the in-flight writers.
// Optional feature macro: RISCV_OPSEL_FWD_EN
//   defined   : lowest-index matching writer supplies the data; a stall is
//               raised only if that writer's result is still pending.
//   undefined : register-file data is always used; any match stalls.
// Ports:
//   rs_addr     in  5                   source register index
//   rs_data     in  WORD_LENGTH         register-file read data
//   fwd_valid   in  NUM_FWD             writer k is valid
//   fwd_pending in  NUM_FWD             writer k result not yet available
//   fwd_rd      in  NUM_FWD x 5         writer k destination
//   fwd_data    in  NUM_FWD x WORD_LENGTH writer k result
//   op_data     out WORD_LENGTH         resolved operand value
//   stall       out 1                   operand cannot be resolved this cycle
// ---------------------------------------------------------------------------
import riscv_constants::*;

module riscv_fwd_unit #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_FWD     = 2
) (
  input  logic [4:0]                            rs_addr,
  input  logic [WORD_LENGTH-1:0]                rs_data,
  input  logic [NUM_FWD-1:0]                    fwd_valid,
  input  logic [NUM_FWD-1:0]                    fwd_pending,
  input  logic [NUM_FWD-1:0][4:0]               fwd_rd,
  input  logic [NUM_FWD-1:0][WORD_LENGTH-1:0]   fwd_data,
  output logic [WORD_LENGTH-1:0]                op_data,
  output logic                                  stall
);

  logic                   hit;
  logic                   hitPending;
  logic [WORD_LENGTH-1:0] hitData;

  // Priority search: walk from the highest index down so that a lower-index
  // match overwrites any higher one, leaving source 0 as the winner.
  always_comb begin
    hit        = 1'b0;
    hitPending = 1'b0;
    hitData    = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (regMatch(fwd_valid[k], fwd_rd[k], rs_addr)) begin
        hit        = 1'b1;
        hitPending = fwd_pending[k];
        hitData    = fwd_data[k];
      end
    end
  end

`ifdef RISCV_OPSEL_FWD_EN
  // Bypass the register file with the winning writer's result; only a
  // still-pending result (e.g. load-use) has to hold the instruction back.
  assign op_data = hit ? hitData : rs_data;
  assign stall   = hit & hitPending;
`else
  // Without bypass paths the register file is the only source, so any
  // outstanding writer to this register must be waited out.
  logic unusedFwd;
  assign unusedFwd = ^{hitPending, hitData};
  assign op_data   = rs_data;
  assign stall     = hit;
`endif

endmodule

// File: rtl/riscv_opsel_stage.sv
// ---------------------------------------------------------------------------
// riscv_opsel_stage
// Operand-select pipeline stage: picks operand 1/2 from registers (with
// forwarding), PC or immediates, stalls on unresolved hazards and registers
// the pair behind a valid/ready handshake with one cycle of latency.
// Optional feature macro: RISCV_OPSEL_FWD_EN (enables the bypass paths in
// riscv_fwd_unit; the port list is the same either way).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        upstream handshake (in_ready combinational)
//   op1_sel, op2_sel           operand source selects
//   rs1_addr, rs2_addr         source register indices
//   rs1_data, rs2_data, pc,
//   imm_z_uext, imm            candidate operand values
//   fwd_valid, fwd_pending,
//   fwd_rd, fwd_data           in-flight writer information (index 0 first)
//   flush                      drops held and incoming operands
//   out_valid / out_ready      downstream handshake
//   op1, op2                   registered operands
//   stall_cnt                  saturating count of hazard stall cycles
// ---------------------------------------------------------------------------
import riscv_constants::*;

module riscv_opsel_stage #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_FWD     = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  OP1_SEL                              op1_sel,
  input  OP2_SEL                              op2_sel,
  input  logic [4:0]                          rs1_addr,
  input  logic [4:0]                          rs2_addr,
  input  logic [WORD_LENGTH-1:0]              rs1_data,
  input  logic [WORD_LENGTH-1:0]              rs2_data,
  input  logic [WORD_LENGTH-1:0]              pc,
  input  logic [WORD_LENGTH-1:0]              imm_z_uext,
  input  logic [WORD_LENGTH-1:0]              imm,
  input  logic [NUM_FWD-1:0]                  fwd_valid,
  input  logic [NUM_FWD-1:0]                  fwd_pending,
  input  logic [NUM_FWD-1:0][4:0]             fwd_rd,
  input  logic [NUM_FWD-1:0][WORD_LENGTH-1:0] fwd_data,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_LENGTH-1:0]              op1,
  output logic [WORD_LENGTH-1:0]              op2,
  output logic [CNT_WIDTH-1:0]                stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [WORD_LENGTH-1:0] fwdOp1, fwdOp2;
  logic                   stall1, stall2;
  logic [WORD_LENGTH-1:0] op1Res, op2Res;
  logic                   hazard;
  logic                   transfer;

  logic                   outValid_q, outValid_d;
  logic [WORD_LENGTH-1:0] op1_q, op1_d;
  logic [WORD_LENGTH-1:0] op2_q, op2_d;
  logic [CNT_WIDTH-1:0]   stallCnt_q, stallCnt_d;

  riscv_fwd_unit #(.WORD_LENGTH(WORD_LENGTH), .NUM_FWD(NUM_FWD)) u_fwdRs1 (
    .rs_addr     (rs1_addr),
    .rs_data     (rs1_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .op_data     (fwdOp1),
    .stall       (stall1)
  );

  riscv_fwd_unit #(.WORD_LENGTH(WORD_LENGTH), .NUM_FWD(NUM_FWD)) u_fwdRs2 (
    .rs_addr     (rs2_addr),
    .rs_data     (rs2_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .op_data     (fwdOp2),
    .stall       (stall2)
  );

  // Operand multiplexers; unassigned select encodings yield zero.
  always_comb begin
    op1Res = '0;
    case (op1_sel)
      OP1_RS1: op1Res = fwdOp1;
      OP1_PC:  op1Res = pc;
      OP1_IMZ: op1Res = imm_z_uext;
      default: op1Res = '0;
    endcase
    op2Res = '0;
    case (op2_sel)
      OP2_RS2: op2Res = fwdOp2;
      OP2_IMM: op2Res = imm;
      default: op2Res = '0;
    endcase
  end

  // A register hazard only matters for an operand that actually reads it.
  assign hazard   = ((op1_sel == OP1_RS1) && stall1) ||
                    ((op2_sel == OP2_RS2) && stall2);
  assign in_ready = !flush && !hazard && (!outValid_q || out_ready);
  assign transfer = in_valid && in_ready;

  // Next-state: flush wins, then a new capture (which also covers the
  // simultaneous drain+fill case), then a plain drain. Operands only move on
  // capture so a stalled consumer sees them stable.
  always_comb begin
    outValid_d = outValid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    stallCnt_d = stallCnt_q;
    if (flush) begin
      outValid_d = 1'b0;
    end else if (transfer) begin
      outValid_d = 1'b1;
      op1_d      = op1Res;
      op2_d      = op2Res;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
    if (!flush && in_valid && hazard && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
  end

  // State registers; reset empties the stage and clears the stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      stallCnt_q <= '0;
    end else begin
      outValid_q <= outValid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign out_valid = outValid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_riscv_opsel_stage.sv
// ---------------------------------------------------------------------------
// tb_riscv_opsel_stage
// Directed bench for riscv_opsel_stage with a cycle-level reference model.
// Works with or without RISCV_OPSEL_FWD_EN; expectations follow the macro.
// ---------------------------------------------------------------------------
import riscv_constants::*;

module tb_riscv_opsel_stage;

  localparam int WL = 32;
  localparam int NF = 2;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  OP1_SEL                 op1_sel;
  OP2_SEL                 op2_sel;
  logic [4:0]             rs1_addr, rs2_addr;
  logic [WL-1:0]          rs1_data, rs2_data, pc, imm_z_uext, imm;
  logic [NF-1:0]          fwd_valid, fwd_pending;
  logic [NF-1:0][4:0]     fwd_rd;
  logic [NF-1:0][WL-1:0]  fwd_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [WL-1:0]          op1, op2;
  logic [CW-1:0]          stall_cnt;

  int nChecks = 0;
  int nErrors = 0;

  riscv_opsel_stage #(.WORD_LENGTH(WL), .NUM_FWD(NF), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op1_sel     (op1_sel),
    .op2_sel     (op2_sel),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .pc          (pc),
    .imm_z_uext  (imm_z_uext),
    .imm         (imm),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op1         (op1),
    .op2         (op2),
    .stall_cnt   (stall_cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it if it disagrees.
  task automatic checkOutput(input string name, input logic [WL-1:0] act,
                             input logic [WL-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs set beforehand are sampled at this edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    in_valid    = 1'b0;
    op1_sel     = OP1_RS1;
    op2_sel     = OP2_IMM;
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;
    rs1_data    = '0;
    rs2_data    = '0;
    pc          = '0;
    imm_z_uext  = '0;
    imm         = '0;
    fwd_valid   = '0;
    fwd_pending = '0;
    fwd_rd      = '0;
    fwd_data    = '0;
    flush       = 1'b0;
    out_ready   = 1'b1;
  endtask

  // Reference model: a register source scans the writers in priority order
  // and the first match decides. Result is {cannot-proceed, value}.
  function automatic logic [WL:0] resolveReg(input logic [4:0] addr,
                                             input logic [WL-1:0] regData);
    for (int k = 0; k < NF; k++) begin
      if (fwd_valid[k] && fwd_rd[k] == addr && addr != 5'd0) begin
`ifdef RISCV_OPSEL_FWD_EN
        return {fwd_pending[k], fwd_data[k]};
`else
        return {1'b1, regData};
`endif
      end
    end
    return {1'b0, regData};
  endfunction

  function automatic logic [WL-1:0] expOp1();
    logic [WL:0] r;
    r = resolveReg(rs1_addr, rs1_data);
    if (op1_sel == OP1_RS1) return r[WL-1:0];
    if (op1_sel == OP1_PC)  return pc;
    if (op1_sel == OP1_IMZ) return imm_z_uext;
    return '0;
  endfunction

  function automatic logic [WL-1:0] expOp2();
    logic [WL:0] r;
    r = resolveReg(rs2_addr, rs2_data);
    if (op2_sel == OP2_RS2) return r[WL-1:0];
    if (op2_sel == OP2_IMM) return imm;
    return '0;
  endfunction

  function automatic logic expHazard();
    logic [WL:0] r1, r2;
    r1 = resolveReg(rs1_addr, rs1_data);
    r2 = resolveReg(rs2_addr, rs2_data);
    return ((op1_sel == OP1_RS1) && r1[WL]) || ((op2_sel == OP2_RS2) && r2[WL]);
  endfunction

  logic          mOutValid;
  logic [WL-1:0] mOp1, mOp2;
  int            mStalls;

  function automatic logic expReady();
    return !flush && !expHazard() && (!mOutValid || out_ready);
  endfunction

  function automatic logic [WL-1:0] expCnt();
    return (mStalls > CNT_MAX) ? WL'(CNT_MAX) : WL'(mStalls);
  endfunction

  // Model state: one operand pair slot plus an unbounded stall tally.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOutValid <= 1'b0;
      mOp1      <= '0;
      mOp2      <= '0;
      mStalls   <= 0;
    end else begin
      if (flush) begin
        mOutValid <= 1'b0;
      end else if (in_valid && expReady()) begin
        mOutValid <= 1'b1;
        mOp1      <= expOp1();
        mOp2      <= expOp2();
      end else if (out_ready) begin
        mOutValid <= 1'b0;
      end
      if (!flush && in_valid && expHazard()) mStalls <= mStalls + 1;
    end
  end

  // Every cycle out of reset: DUT against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model out_valid", WL'(out_valid), WL'(mOutValid));
      checkOutput("model op1", op1, mOp1);
      checkOutput("model op2", op2, mOp2);
      checkOutput("model stall_cnt", WL'(stall_cnt), expCnt());
      checkOutput("model in_ready", WL'(in_ready), WL'(expReady()));
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    setIdle();
    rst_n = 1'b0;
    #12;
    checkOutput("reset out_valid", WL'(out_valid), 0);
    checkOutput("reset op1", op1, 0);
    checkOutput("reset op2", op2, 0);
    checkOutput("reset stall_cnt", WL'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] no-match transfer");
    op1_sel = OP1_RS1; rs1_addr = 5'd3; rs1_data = 32'h11;
    op2_sel = OP2_IMM; imm = 32'h22; in_valid = 1'b1;
    #1;
    checkOutput("nomatch in_ready", WL'(in_ready), 1);
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("nomatch out_valid", WL'(out_valid), 1);
    checkOutput("nomatch op1", op1, 32'h11);
    checkOutput("nomatch op2", op2, 32'h22);

    $display("[TB] forwarding priority");
    rs1_addr = 5'd5; fwd_valid = 2'b11; fwd_pending = 2'b00;
    fwd_rd[0] = 5'd5; fwd_rd[1] = 5'd5;
    fwd_data[0] = 32'hAA; fwd_data[1] = 32'hBB; in_valid = 1'b1;
    #1;
`ifdef RISCV_OPSEL_FWD_EN
    checkOutput("prio in_ready", WL'(in_ready), 1);
    applyStimulus();
    checkOutput("prio op1", op1, 32'hAA);
    checkOutput("prio out_valid", WL'(out_valid), 1);
`else
    checkOutput("prio in_ready", WL'(in_ready), 0);
    applyStimulus();
    checkOutput("prio out_valid", WL'(out_valid), 0);
    checkOutput("prio stall_cnt", WL'(stall_cnt), 1);
`endif
    in_valid = 1'b0; fwd_valid = '0;

    $display("[TB] x0 never forwards or stalls");
    op1_sel = OP1_PC; pc = 32'h100;
    op2_sel = OP2_RS2; rs2_addr = 5'd0; rs2_data = 32'h33;
    fwd_valid = 2'b01; fwd_rd[0] = 5'd0; fwd_pending = 2'b01; in_valid = 1'b1;
    #1;
    checkOutput("x0 in_ready", WL'(in_ready), 1);
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("x0 op1", op1, 32'h100);
    checkOutput("x0 op2", op2, 32'h33);
`ifdef RISCV_OPSEL_FWD_EN
    checkOutput("x0 stall_cnt", WL'(stall_cnt), 0);
`else
    checkOutput("x0 stall_cnt", WL'(stall_cnt), 1);
`endif

    $display("[TB] load-use stall");
    op1_sel = OP1_RS1; rs1_addr = 5'd7; rs1_data = 32'h70;
    op2_sel = OP2_IMM; imm = 32'h44;
    fwd_valid = 2'b01; fwd_rd[0] = 5'd7; fwd_data[0] = 32'h77;
    fwd_pending = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("loaduse in_ready", WL'(in_ready), 0);
      applyStimulus();
    end
    fwd_pending = 2'b00;
`ifdef RISCV_OPSEL_FWD_EN
    checkOutput("loaduse stall_cnt", WL'(stall_cnt), 3);
    #1;
    checkOutput("loaduse release in_ready", WL'(in_ready), 1);
    applyStimulus();
    checkOutput("loaduse op1", op1, 32'h77);
    checkOutput("loaduse op2", op2, 32'h44);
    checkOutput("loaduse final stall_cnt", WL'(stall_cnt), 3);
`else
    checkOutput("loaduse stall_cnt", WL'(stall_cnt), 4);
    #1;
    checkOutput("loaduse match in_ready", WL'(in_ready), 0);
    fwd_valid = '0;
    #1;
    checkOutput("loaduse release in_ready", WL'(in_ready), 1);
    applyStimulus();
    checkOutput("loaduse op1", op1, 32'h70);
    checkOutput("loaduse final stall_cnt", WL'(stall_cnt), 4);
`endif
    in_valid = 1'b0; fwd_valid = '0; fwd_pending = '0;

    $display("[TB] backpressure and flush");
    rs1_addr = 5'd3; rs1_data = 32'h55; imm = 32'h66; in_valid = 1'b1;
    applyStimulus();
    checkOutput("bp capture op1", op1, 32'h55);
    out_ready = 1'b0; rs1_data = 32'h5A; imm = 32'h6A;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("bp in_ready", WL'(in_ready), 0);
      applyStimulus();
      checkOutput("bp op1", op1, 32'h55);
      checkOutput("bp op2", op2, 32'h66);
      checkOutput("bp out_valid", WL'(out_valid), 1);
    end
    flush = 1'b1; rs1_data = 32'h99;
    #1;
    checkOutput("flush in_ready", WL'(in_ready), 0);
    applyStimulus();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush out_valid", WL'(out_valid), 0);
    checkOutput("flush op1", op1, 32'h55);
    out_ready = 1'b1;

    $display("[TB] reset during hold");
    rs1_data = 32'h12; in_valid = 1'b1;
    applyStimulus();
    out_ready = 1'b0; in_valid = 1'b0;
    applyStimulus();
    checkOutput("hold out_valid", WL'(out_valid), 1);
    checkOutput("hold op1", op1, 32'h12);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", WL'(out_valid), 0);
    checkOutput("async reset op1", op1, 0);
    checkOutput("async reset op2", op2, 0);
    checkOutput("async reset stall_cnt", WL'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rs1_data = 32'h34; in_valid = 1'b1; out_ready = 1'b1;
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("post-reset out_valid", WL'(out_valid), 1);
    checkOutput("post-reset op1", op1, 32'h34);

    $display("[TB] stall counter saturation");
    rs1_addr = 5'd9; fwd_valid = 2'b01; fwd_rd[0] = 5'd9;
    fwd_pending = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("saturated stall_cnt", WL'(stall_cnt), 15);
    in_valid = 1'b0; fwd_valid = '0; fwd_pending = '0;
    applyStimulus();
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/riscv_opsel_stage.md
RISCV_OPSEL_STAGE -- requirements
Module: riscv_opsel_stage

Interface
REQ-001 Parameter WORD_LENGTH, default 32, is the operand and data width.
REQ-002 Parameter NUM_FWD, default 2, is the number of forwarding sources; the legal range is 1..4, and index 0 has the highest priority.
REQ-003 Parameter CNT_WIDTH, default 16, is the width of the stall counter.
REQ-004 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  is the reset: asynchronous assert, active-low.
REQ-006 in_valid  in  1 / in_ready  out  1  form the upstream handshake; a transfer occurs when both are high.
REQ-007 op1_sel  in  OP1_SEL  selects operand 1: OP1_RS1, OP1_PC or OP1_IMZ.
REQ-008 op2_sel  in  OP2_SEL  selects operand 2: OP2_RS2 or OP2_IMM.
REQ-009 rs1_addr, rs2_addr  in  5 each  are the source register indices.
REQ-010 rs1_data, rs2_data, pc, imm_z_uext, imm  in  WORD_LENGTH each  are the candidate operand values.
REQ-011 fwd_valid, fwd_pending  in  NUM_FWD  are per source: the writer is valid, and its data is not yet available.
REQ-012 fwd_rd  in  NUM_FWD x 5 / fwd_data  in  NUM_FWD x WORD_LENGTH  are the writer destination and its result.
REQ-013 flush  in  1  discards the held and incoming operands.
REQ-014 out_valid  out  1 / out_ready  in  1  form the downstream handshake.
REQ-015 op1, op2  out  WORD_LENGTH  are the registered operands.
REQ-016 stall_cnt  out  CNT_WIDTH  counts hazard stall cycles.

Function
REQ-017 A source k matches rs1 when fwd_valid[k]=1, fwd_rd[k]==rs1_addr and rs1_addr!=0; rs2 matches the same way.
REQ-018 Operand 1 resolves as follows:
- OP1_RS1: fwd_data of the lowest-index matching source; if none matches, rs1_data.
- OP1_PC: pc.
- OP1_IMZ: imm_z_uext.
- Any other encoding: 0.
REQ-019 Operand 2 resolves as follows:
- OP2_RS2: fwd_data of the lowest-index matching source; if none matches, rs2_data.
- OP2_IMM: imm.
- Any other encoding: 0.
REQ-020 hazard is high when a used register operand's lowest-index match has fwd_pending=1; an operand not selected as RS1/RS2 never causes a hazard.
REQ-021 in_ready = !hazard && (!out_valid || out_ready); it is combinational.
REQ-022 On transfer, op1 and op2 capture the resolved values and out_valid is set next cycle; latency is 1 cycle.
REQ-023 When out_valid=1 and out_ready=0, op1 and op2 hold stable.
REQ-024 When out_valid=1, out_ready=1 and no transfer occurs, out_valid clears next cycle.
REQ-025 Simultaneous drain and transfer are allowed and give full throughput, one operand pair per cycle.
REQ-026 flush=1 clears out_valid next cycle, ignores in_valid that cycle and forces in_ready=0; flush has priority over all other events.
REQ-027 stall_cnt increments each cycle in which in_valid=1 and hazard=1; it saturates at all-ones and does not wrap.

Reset
REQ-028 While rst_n=0, out_valid=0, op1=0, op2=0 and stall_cnt=0, taking effect immediately without a clock edge.
REQ-029 A reset during a held output discards the operand pair; the first transfer after release behaves as if from an idle state.

Configuration
REQ-030 Macro RISCV_OPSEL_FWD_EN defined: forwarding operates as specified in REQ-017..REQ-020.
REQ-031 Macro RISCV_OPSEL_FWD_EN undefined: fwd_data is never selected, and any match stalls regardless of fwd_pending; hazard = any used-operand match.
REQ-032 The port list is identical with and without RISCV_OPSEL_FWD_EN.

Structure
REQ-033 The OP1_SEL and OP2_SEL enums (including OP2_RS2 and OP2_IMM) belong in the shared riscv_constants package.
REQ-034 Sub-module riscv_fwd_unit is instantiated once per register operand and performs priority match, data select and pending detect.

Verification
REQ-035 No match: op1_sel=OP1_RS1, rs1_data=0x11, out_ready=1 -> op1=0x11, out_valid=1 one cycle after the transfer.
REQ-036 Priority: fwd 0 and fwd 1 both match rs1_addr=5, data 0xAA/0xBB, not pending -> op1=0xAA.
REQ-037 x0: rs2_addr=0 with fwd_rd[0]=0, fwd_valid[0]=1, fwd_pending[0]=1 -> no stall, op2=rs2_data.
REQ-038 Load-use: fwd_pending[0]=1 matching rs1 for 3 cycles -> in_ready=0 for those 3 cycles, stall_cnt=3, then transfer with fwd_data.
REQ-039 Backpressure and flush:
- out_ready=0 for 4 cycles -> op1/op2 stable, in_ready=0.
- flush with in_valid=1 -> out_valid=0 next cycle, no capture.
REQ-040 Saturation and reset: CNT_WIDTH=4 with 20 stall cycles -> stall_cnt=15; rst_n low mid-hold -> out_valid=0 immediately.
